// File: rtl/voice_scheduler.sv
// rtl/voice_scheduler.sv - time-multiplexed voice phase scheduler sharing one sine unit; optional frame mix via VOICE_SCHEDULER_MIX_EN
module voice_scheduler #(
    parameter int NVOICE = 8,
    parameter int PW     = 21,
    parameter int SW     = 17,
    localparam int IW    = $clog2(NVOICE)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_tick,
    input  logic                 cfg_we,
    input  logic [IW-1:0]        cfg_voice,
    input  logic [PW-1:0]        cfg_inc,
    input  logic                 cfg_gate,
    output logic [PW-1:0]        sine_phase,
    input  logic signed [SW-1:0] sine_in,
    output logic signed [SW-1:0] voice_out,
    output logic [IW-1:0]        voice_idx,
    output logic                 voice_valid,
    output logic                 busy,
    output logic                 overrun
`ifdef VOICE_SCHEDULER_MIX_EN
    ,
    output logic signed [SW+3:0] mix_out,
    output logic                 mix_valid
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   cnt;
    logic [PW-1:0]   inc   [NVOICE];
    logic [PW-1:0]   phase [NVOICE];
    logic [NVOICE-1:0] gate;

    // Issue-stage tags travelling alongside sine_phase
    logic            iss_vld;
    logic            iss_gate;
    logic [IW-1:0]   iss_idx;

    logic            start;
    logic            last;

    // Frame start only from a fully idle block; last issue slot detection
    always_comb begin
        start = sample_tick && (state == IDLE) && !busy;
        last  = (cnt == IW'(NVOICE - 1));
    end

    // Next-state logic: IDLE -> ISSUE (NVOICE slots) -> DRAIN (one cycle) -> IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ISSUE;
            ISSUE:   if (last)  state_nxt = DRAIN;
            DRAIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Voice slot counter, restarted on each accepted tick
    always_ff @(posedge clk) begin
        if (rst || start)          cnt <= '0;
        else if (state == ISSUE)   cnt <= cnt + 1'b1;
    end

    // Per-voice config and phase; issue reads pre-edge inc/gate so a same-edge write applies next frame
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NVOICE; i++) begin
                inc[i]   <= '0;
                phase[i] <= '0;
            end
            gate <= '0;
        end else begin
            if (cfg_we) begin
                inc[cfg_voice]  <= cfg_inc;
                gate[cfg_voice] <= cfg_gate;
            end
            if (state == ISSUE) begin
                phase[cnt] <= gate[cnt] ? (phase[cnt] + inc[cnt]) : '0;
            end
        end
    end

    // Issue stage: present the voice phase to the sine unit; sine_phase holds outside ISSUE
    always_ff @(posedge clk) begin
        if (rst) begin
            sine_phase <= '0;
            iss_vld    <= 1'b0;
            iss_gate   <= 1'b0;
            iss_idx    <= '0;
        end else begin
            iss_vld <= (state == ISSUE);
            if (state == ISSUE) begin
                sine_phase <= phase[cnt];
                iss_gate   <= gate[cnt];
                iss_idx    <= cnt;
            end
        end
    end

    // Output stage: capture the sine result, frame busy flag and overrun pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            voice_out   <= '0;
            voice_idx   <= '0;
            voice_valid <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            voice_valid <= iss_vld;
            if (iss_vld) begin
                voice_out <= iss_gate ? sine_in : '0;
                voice_idx <= iss_idx;
            end
            busy    <= (state != IDLE);
            overrun <= sample_tick && (busy || (state != IDLE));
        end
    end

`ifdef VOICE_SCHEDULER_MIX_EN
    logic signed [SW+3:0] acc;
    logic signed [SW+3:0] acc_sum;

    // Running sum including the voice currently on the output
    always_comb begin
        acc_sum = acc + {{4{voice_out[SW-1]}}, voice_out};
    end

    // Frame accumulator; full sum published the cycle after the last voice
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            mix_out   <= '0;
            mix_valid <= 1'b0;
        end else begin
            mix_valid <= 1'b0;
            if (start)            acc <= '0;
            else if (voice_valid) acc <= acc_sum;
            if (voice_valid && (voice_idx == IW'(NVOICE - 1))) begin
                mix_out   <= acc_sum;
                mix_valid <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_voice_scheduler.sv
// tb/tb_voice_scheduler.sv - self-checking bench for voice_scheduler with frame-level reference model
module tb_voice_scheduler;

    localparam int NVOICE = 8;
    localparam int PW     = 21;
    localparam int SW     = 17;
    localparam int IW     = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 sample_tick;
    logic                 cfg_we;
    logic [IW-1:0]        cfg_voice;
    logic [PW-1:0]        cfg_inc;
    logic                 cfg_gate;
    logic [PW-1:0]        sine_phase;
    logic signed [SW-1:0] sine_in;
    logic signed [SW-1:0] voice_out;
    logic [IW-1:0]        voice_idx;
    logic                 voice_valid;
    logic                 busy;
    logic                 overrun;
`ifdef VOICE_SCHEDULER_MIX_EN
    logic signed [SW+3:0] mix_out;
    logic                 mix_valid;
`endif

    logic stub_const;
    int   checks = 0;
    int   passes = 0;
    bit   chk_en = 0;

    always #5 clk = ~clk;

    // Stand-in sine unit: arbitrary but deterministic mapping of phase to sample
    function automatic logic signed [SW-1:0] stub_sine(input logic [PW-1:0] p);
        logic [SW-1:0] t;
        t = p[SW-1:0] ^ 17'h0A5A5 ^ {p[PW-1:PW-4], 13'd0};
        return $signed(t);
    endfunction

    function automatic logic signed [SW-1:0] exp_sine(input logic [PW-1:0] p);
        if (stub_const) return 17'sd65535;
        return stub_sine(p);
    endfunction

    assign sine_in = stub_const ? 17'sd65535 : stub_sine(sine_phase);

    voice_scheduler #(.NVOICE(NVOICE), .PW(PW), .SW(SW)) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_tick (sample_tick),
        .cfg_we      (cfg_we),
        .cfg_voice   (cfg_voice),
        .cfg_inc     (cfg_inc),
        .cfg_gate    (cfg_gate),
        .sine_phase  (sine_phase),
        .sine_in     (sine_in),
        .voice_out   (voice_out),
        .voice_idx   (voice_idx),
        .voice_valid (voice_valid),
        .busy        (busy),
        .overrun     (overrun)
`ifdef VOICE_SCHEDULER_MIX_EN
        ,
        .mix_out     (mix_out),
        .mix_valid   (mix_valid)
`endif
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: frames described by start edge fs; voice v issued at edge fs+1+v,
    // seen on the output after edge fs+2+v; busy after edges fs+1..fs+NVOICE+1.
    int                   cyc = 0;
    int                   fs  = -1000;
    int                   mv;
    int                   m_sum;
    logic [PW-1:0]        m_inc   [NVOICE];
    logic [PW-1:0]        m_phase [NVOICE];
    logic                 m_gate  [NVOICE];
    logic [PW-1:0]        m_sp;
    logic signed [SW-1:0] mo;
    bit                   e_vld [int];
    int                   e_idx [int];
    logic signed [SW-1:0] e_out [int];
    bit                   e_ovr [int];
    int                   e_mix [int];
    logic [PW-1:0]        v0_sp[$];
    logic [PW-1:0]        v2_sp[$];
    logic [PW-1:0]        v3_sp[$];

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            for (int i = 0; i < NVOICE; i++) begin
                m_inc[i] = '0; m_phase[i] = '0; m_gate[i] = 1'b0;
            end
            m_sp = '0;
            fs   = -1000;
            e_vld.delete(); e_idx.delete(); e_out.delete(); e_ovr.delete(); e_mix.delete();
        end else begin
            if (sample_tick) begin
                if (cyc >= fs + 1 && cyc <= fs + NVOICE + 2) e_ovr[cyc] = 1'b1;
                else begin
                    fs    = cyc;
                    m_sum = 0;
                end
            end
            if (cyc >= fs + 1 && cyc <= fs + NVOICE) begin
                mv   = cyc - fs - 1;
                m_sp = m_phase[mv];
                mo   = m_gate[mv] ? exp_sine(m_phase[mv]) : '0;
                e_vld[cyc+1] = 1'b1;
                e_idx[cyc+1] = mv;
                e_out[cyc+1] = mo;
                m_sum += int'(mo);
                if (mv == NVOICE - 1) e_mix[cyc+2] = m_sum;
                if (mv == 0) v0_sp.push_back(m_phase[0]);
                if (mv == 2) v2_sp.push_back(m_phase[2]);
                if (mv == 3) v3_sp.push_back(m_phase[3]);
                m_phase[mv] = m_gate[mv] ? m_phase[mv] + m_inc[mv] : '0;
            end
            if (cfg_we) begin
                m_inc[cfg_voice]  = cfg_inc;
                m_gate[cfg_voice] = cfg_gate;
            end
        end
    end

    int vv_cnt  = 0;
    int ovr_cnt = 0;
    int mix_cnt = 0;
    int last_mix = 0;

    // Per-cycle comparison of every DUT output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("voice_valid", voice_valid, e_vld.exists(cyc));
            chk("busy", busy, (cyc >= fs + 1 && cyc <= fs + NVOICE + 1));
            chk("overrun", overrun, e_ovr.exists(cyc));
            chk("sine_phase", sine_phase, m_sp);
            if (voice_valid && e_vld.exists(cyc)) begin
                chk("voice_idx", voice_idx, e_idx[cyc]);
                chk("voice_out", voice_out, e_out[cyc]);
            end
            if (voice_valid) vv_cnt++;
            if (overrun) ovr_cnt++;
`ifdef VOICE_SCHEDULER_MIX_EN
            chk("mix_valid", mix_valid, e_mix.exists(cyc));
            if (mix_valid && e_mix.exists(cyc)) chk("mix_out", mix_out, e_mix[cyc]);
            if (mix_valid) begin
                mix_cnt++;
                last_mix = int'(mix_out);
            end
`endif
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic do_tick();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
    endtask

    task automatic cfg(input int v, input int inc, input bit g);
        cfg_we = 1'b1; cfg_voice = IW'(v); cfg_inc = PW'(inc); cfg_gate = g;
        step();
        cfg_we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sample_tick = 1'b0; cfg_we = 1'b0;
        cfg_voice = '0; cfg_inc = '0; cfg_gate = 1'b0; stub_const = 1'b0;
        idle(2);
        chk_en = 1'b1;
        step();
        chk("rst_sine_phase", sine_phase, 0);
        chk("rst_voice_valid", voice_valid, 0);
        rst = 1'b0;
        step();

        // Voice 0 counting by one, others silent
        cfg(0, 1, 1'b1);
        repeat (3) begin do_tick(); idle(12); end
        chk("v0_frames", v0_sp.size(), 3);
        for (int k = 0; k < 3; k++) chk("v0_phase_seq", v0_sp[k], k);

        // Voice 3 wrap at full-scale increment
        cfg(3, 2097151, 1'b1);
        v3_sp.delete();
        repeat (3) begin do_tick(); idle(12); end
        chk("v3_phase_0", v3_sp[0], 0);
        chk("v3_phase_1", v3_sp[1], 2097151);
        chk("v3_phase_2", v3_sp[2], 2097150);

        // More voices active, then a tick four cycles into a frame
        cfg(5, 123457, 1'b1);
        cfg(6, 1048576, 1'b1);
        vv_cnt = 0; ovr_cnt = 0;
        do_tick(); idle(3); do_tick(); idle(14);
        chk("overlap_valid_count", vv_cnt, 8);
        chk("overlap_overrun_count", ovr_cnt, 1);

        // Tick on the edge where busy falls is an overrun; one edge later is accepted
        vv_cnt = 0; ovr_cnt = 0;
        do_tick(); idle(9); do_tick(); idle(14);
        chk("boundary_overrun_count", ovr_cnt, 1);
        chk("boundary_valid_count", vv_cnt, 8);
        vv_cnt = 0; ovr_cnt = 0;
        do_tick(); idle(10); do_tick(); idle(14);
        chk("accept_overrun_count", ovr_cnt, 0);
        chk("accept_valid_count", vv_cnt, 16);

        // Reset at edge T+5 aborts the frame
        do_tick(); idle(4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_voice_valid", voice_valid, 0);
        chk("abort_busy", busy, 0);
        vv_cnt = 0;
        idle(12);
        chk("abort_no_valid", vv_cnt, 0);

        // Same-edge config write to the voice being issued
        cfg(2, 10, 1'b1);
        v2_sp.delete();
        do_tick(); idle(12);
        do_tick(); idle(2); cfg(2, 100, 1'b1); idle(10);
        do_tick(); idle(12);
        do_tick(); idle(12);
        chk("v2_phase_0", v2_sp[0], 0);
        chk("v2_phase_1", v2_sp[1], 10);
        chk("v2_phase_2", v2_sp[2], 20);
        chk("v2_phase_3", v2_sp[3], 120);

`ifdef VOICE_SCHEDULER_MIX_EN
        // Full-scale constant sine on all voices
        for (int v = 0; v < NVOICE; v++) cfg(v, 7 * v + 1, 1'b1);
        stub_const = 1'b1;
        mix_cnt = 0;
        do_tick(); idle(12);
        chk("mix_count", mix_cnt, 1);
        chk("mix_full_scale", last_mix, 524280);
        stub_const = 1'b0;
`endif

        idle(3);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/voice_scheduler.md
VOICE_SCHEDULER -- requirements
Module: voice_scheduler

Interface
REQ-001 Parameters SHALL be: NVOICE, default 8, number of voices (power of 2, 2..16); PW, default 21, phase width; SW, default 17, signed sine sample width.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  in  1  single system clock, rising edge.
  rst  in  1  synchronous active-high reset.
  sample_tick  in  1  one-cycle pulse that starts one sample frame.
  cfg_we  in  1  configuration write strobe.
  cfg_voice  in  log2(NVOICE)  voice written.
  cfg_inc  in  PW  phase increment written.
  cfg_gate  in  1  voice gate written (1 = sounding).
  sine_phase  out  PW  registered phase to the shared combinational sine unit.
  sine_in  in  SW signed  sine unit result for sine_phase, same cycle.
  voice_out  out  SW signed  per-voice sample.
  voice_idx  out  log2(NVOICE)  voice of voice_out.
  voice_valid  out  1  voice_out/voice_idx valid this cycle.
  busy  out  1  frame in progress.
  overrun  out  1  one-cycle pulse: sample_tick arrived while busy.
  mix_out  out  SW+4 signed  frame mix (MIX_EN only).
  mix_valid  out  1  mix_out valid pulse (MIX_EN only).

Function
REQ-003 Block SHALL hold per-voice registers inc[v] (PW), gate[v] (1), phase[v] (PW) and share one sine unit across all voices in time order.
REQ-004 FSM SHALL have states IDLE, ISSUE, DRAIN; IDLE -> ISSUE on sample_tick; ISSUE lasts NVOICE cycles, issuing voices 0..NVOICE-1 in order; ISSUE -> DRAIN after voice NVOICE-1; DRAIN -> IDLE after one cycle.
REQ-005 In ISSUE for voice v, sine_phase SHALL be loaded with current phase[v] and phase[v] SHALL be updated to (phase[v]+inc[v]) mod 2^PW if gate[v]=1, else to 0.
REQ-006 One cycle after sine_phase carries voice v, voice_out SHALL equal sine_in (or 0 if gate[v] was 0 at issue), voice_idx SHALL equal v, voice_valid SHALL be 1.
REQ-007 Latency: tick sampled at edge T -> voice v valid in cycle following edge T+2+v; voice_valid high exactly NVOICE consecutive cycles per frame.
REQ-008 busy SHALL be 1 from edge T+1 through the cycle of the last voice_valid, else 0.
REQ-009 sample_tick while busy=1 SHALL be ignored and SHALL pulse overrun for one cycle; the running frame SHALL be unaffected.
REQ-010 sample_tick in the DRAIN cycle's final edge (busy falling) SHALL count as busy and overrun.
REQ-011 cfg_we SHALL write inc[cfg_voice] and gate[cfg_voice] at the clock edge, in any state.
REQ-012 Config write to the voice being issued on the same edge: issue SHALL use old inc/gate; new values apply from the next frame.
REQ-013 Phase addition SHALL wrap modulo 2^PW with no saturation or flag.
REQ-014 sine_phase SHALL hold its last value outside ISSUE.

Reset
REQ-015 rst SHALL, at the clock edge, force state IDLE and clear inc, gate, phase, sine_phase, voice_out, voice_idx, voice_valid, busy, overrun, mix_out, mix_valid to 0.
REQ-016 rst mid-frame SHALL abort the frame; no further voice_valid until a new sample_tick after rst deasserts.
REQ-017 rst SHALL take priority over sample_tick and cfg_we in the same cycle.

Configuration
REQ-018 Macro VOICE_SCHEDULER_MIX_EN defined: mix_out/mix_valid SHALL exist; accumulator SHALL clear at frame start, add sign-extended voice_out on each voice_valid, and present the full sum with a one-cycle mix_valid on the cycle after the last voice_valid.
REQ-019 Macro undefined: mix_out, mix_valid and accumulator SHALL be absent; all other behaviour identical.

Verification
REQ-020 Voice 0 inc=1 gate=1, others gate=0; three ticks -> voice 0 sine_phase 0,1,2; voices 1..7 voice_out 0.
REQ-021 Voice 3 inc=2097151 gate=1; two ticks -> sine_phase 0 then 2097151 (wrap); third tick -> 2097150.
REQ-022 Tick, second tick 4 cycles later -> overrun one-cycle pulse, exactly 8 voice_valid, idx 0..7 contiguous.
REQ-023 rst asserted at edge T+5 of a frame -> voice_valid 0 next cycle, all phases 0, busy 0.
REQ-024 cfg_we to voice 2 (inc=100) on its issue edge -> frame uses old inc; next frame advances by 100.
REQ-025 MIX_EN, all 8 voices gated, stub sine_in=65535 -> mix_out=524280 one cycle after last voice_valid.
